// File: rtl/lz77_token_flow_ctrl.sv
// rtl/lz77_token_flow_ctrl.sv - LZ77 output-path flow controller: in-flight tracking, token FIFO, frame FSM
module lz77_token_flow_ctrl #(
  parameter int DATA_WIDTH           = 8,
  parameter int DICTIONARY_DEPTH_LOG = 16,
  parameter int CNT_WIDTH            = 9,
  parameter int FIFO_DEPTH_LOG       = 4,
  parameter int PIPE_LATENCY         = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          enc_valid_symbol,
  output logic                          enc_stall,
  input  logic [DICTIONARY_DEPTH_LOG:0] flt_match_position,
  input  logic [CNT_WIDTH-1:0]          flt_match_length,
  input  logic [DATA_WIDTH-1:0]         flt_match_next_symbol,
  input  logic                          flt_match_valid,
  input  logic                          flt_last_symbol,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DICTIONARY_DEPTH_LOG:0] out_position,
  output logic [CNT_WIDTH-1:0]          out_length,
  output logic [DATA_WIDTH-1:0]         out_next_symbol,
  output logic                          out_is_match,
  output logic                          out_last,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          overflow_err,
  output logic                          protocol_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int POS_W = DICTIONARY_DEPTH_LOG + 1;
  localparam int TOK_W = POS_W + CNT_WIDTH + DATA_WIDTH + 2;
  localparam int INF_W = $clog2(PIPE_LATENCY + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [PIPE_LATENCY-1:0]   pipe_q;
  logic [PIPE_LATENCY-1:0]   pipe_nx;
  logic [INF_W-1:0]          inflight_nx;
  logic [TOK_W-1:0]          mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG:0]   occ;
  logic [FIFO_DEPTH_LOG:0]   occ_nx;
  logic [TOK_W-1:0]          tok_in;
  logic [TOK_W-1:0]          head;
  logic                      track;
  logic                      tok_wr;
  logic                      full;
  logic                      empty;
  logic                      wr_en;
  logic                      rd_en;
  logic                      head_last;
  logic                      stall_nx;

  // Only symbols the encoder was allowed to send are followed through the filter.
  assign track   = enc_valid_symbol & (state == RUN) & ~enc_stall;
  assign pipe_nx = (pipe_q << 1) | PIPE_LATENCY'(track);
  assign tok_wr  = pipe_q[PIPE_LATENCY-1];

  assign empty = (occ == '0);
  assign full  = (occ == (FIFO_DEPTH_LOG+1)'(DEPTH));
  assign wr_en = tok_wr & ~full;
  assign rd_en = ~empty & out_ready;

  assign tok_in    = {flt_match_position, flt_match_length, flt_match_next_symbol,
                      flt_match_valid, flt_last_symbol};
  assign head      = mem[rd_ptr];
  assign head_last = head[0];

  always_comb begin
    occ_nx = occ;
    if (wr_en && !rd_en) begin
      occ_nx = occ + 1'b1;
    end else if (!wr_en && rd_en) begin
      occ_nx = occ - 1'b1;
    end
  end

  always_comb begin
    inflight_nx = '0;
    for (int i = 0; i < PIPE_LATENCY; i++) begin
      inflight_nx = inflight_nx + INF_W'(pipe_nx[i]);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start) state_nx = RUN;
      RUN:     if (tok_wr && flt_last_symbol) state_nx = DRAIN;
      DRAIN:   if (rd_en && head_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Threshold one below depth: a symbol may still be accepted in the cycle before stall is seen.
  always_comb begin
    stall_nx = 1'b1;
    if (state_nx == RUN) begin
      stall_nx = (32'(occ_nx) + 32'(inflight_nx)) >= 32'(DEPTH - 1);
    end
  end

  // Stall comes out of reset high because IDLE always blocks the encoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pipe_q       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      enc_stall    <= 1'b1;
      overflow_err <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state     <= state_nx;
      pipe_q    <= pipe_nx;
      occ       <= occ_nx;
      enc_stall <= stall_nx;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (tok_wr && full) begin
        overflow_err <= 1'b1;
      end
      if (enc_valid_symbol && ((state != RUN) || enc_stall)) begin
        protocol_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= tok_in;
    end
  end

  assign out_valid = ~empty;
  assign {out_position, out_length, out_next_symbol, out_is_match, out_last} =
         empty ? '0 : head;

  assign frame_done = (state == DONE);
  assign busy       = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_lz77_token_flow_ctrl.sv
// tb/tb_lz77_token_flow_ctrl.sv - randomized self-checking bench for lz77_token_flow_ctrl
module tb_lz77_token_flow_ctrl;

  localparam int DW = 8, DL = 16, CW = 9, FL = 4, PL = 3;
  localparam int DEPTH = 1 << FL;
  localparam int TW = DL + 1 + CW + DW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic enc_valid_symbol = 1'b0;
  logic out_ready = 1'b0;
  logic enc_stall, out_valid, out_is_match, out_last, frame_done, busy, overflow_err, protocol_err;
  logic [DL:0] flt_match_position, out_position;
  logic [CW-1:0] flt_match_length, out_length;
  logic [DW-1:0] flt_match_next_symbol, out_next_symbol;
  logic flt_match_valid, flt_last_symbol;

  logic [TW-1:0] in_tok = '0;
  logic [TW-1:0] fp0, fp1, fp2;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] tx[$];
  logic [TW-1:0] held;

  int vectors = 0, miscompares = 0;
  int cyc = 0, done_cnt = 0, last_rd_cyc = -10, first_valid_cyc = -1, first_sym_cyc = 0;

  always #5 clk = ~clk;

  lz77_token_flow_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .enc_valid_symbol(enc_valid_symbol),
    .enc_stall(enc_stall), .flt_match_position(flt_match_position), .flt_match_length(flt_match_length),
    .flt_match_next_symbol(flt_match_next_symbol), .flt_match_valid(flt_match_valid),
    .flt_last_symbol(flt_last_symbol), .out_valid(out_valid), .out_ready(out_ready),
    .out_position(out_position), .out_length(out_length), .out_next_symbol(out_next_symbol),
    .out_is_match(out_is_match), .out_last(out_last), .frame_done(frame_done), .busy(busy),
    .overflow_err(overflow_err), .protocol_err(protocol_err)
  );

  // Fixed-latency filter stand-in: whatever the encoder presents reappears PL cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fp0 <= '0; fp1 <= '0; fp2 <= '0;
    end else begin
      fp0 <= enc_valid_symbol ? in_tok : '0;
      fp1 <= fp0;
      fp2 <= fp1;
    end
  end
  assign {flt_match_position, flt_match_length, flt_match_next_symbol, flt_match_valid, flt_last_symbol} = fp2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_tok(input logic [DL:0] pos, input logic [CW-1:0] len,
                                           input logic [DW-1:0] sym, input logic ism, input logic last);
    return {pos, len, sym, ism, last};
  endfunction

  function automatic logic [TW-1:0] rand_tok(input logic last);
    return mk_tok((DL+1)'($urandom), CW'($urandom), DW'($urandom), 1'($urandom), last);
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: every accepted token must match the oldest legally sent symbol.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_token", 1, 0);
        else check("token", {out_position, out_length, out_next_symbol, out_is_match, out_last},
                   exp_q.pop_front());
        if (out_last) last_rd_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        check("done_timing", cyc, last_rd_cyc + 1);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Sends tx[] honouring stall and drives out_ready per mode (0 always, 1 toggle, 2 random).
  task automatic pump(input int mode);
    int i = 0;
    int budget = 0;
    int done_start = done_cnt;
    while (done_cnt == done_start && budget < 3000) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~out_ready : 1'($urandom_range(0, 1));
      if (i < tx.size() && !enc_stall && (mode != 2 || $urandom_range(0, 3) != 0)) begin
        in_tok = tx[i];
        enc_valid_symbol = 1'b1;
        exp_q.push_back(tx[i]);
        if (i == 0) first_sym_cyc = cyc;
        i++;
      end else begin
        enc_valid_symbol = 1'b0;
      end
      step();
      budget++;
    end
    enc_valid_symbol = 1'b0;
    check("frame_done_seen", done_cnt - done_start, 1);
    check("all_sent", i, tx.size());
    check("sb_empty", exp_q.size(), 0);
    check("busy_after", busy, 0);
  endtask

  task automatic run_frame(input int mode);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pump(mode);
  endtask

  task automatic fill_tx(input int n);
    tx.delete();
    for (int k = 0; k < n; k++) tx.push_back(rand_tok(k == n - 1));
  endtask

  initial begin
    int acc;
    int d0;
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_enc_stall", enc_stall, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_protocol", protocol_err, 0);
    rst_n = 1'b1;
    repeat (2) step();

    fill_tx(4);
    first_valid_cyc = -1;
    run_frame(0);
    check("first_latency", first_valid_cyc - first_sym_cyc, PL + 1);

    tx.delete();
    tx.push_back(mk_tok(17'd37, 9'd5, 8'h00, 1'b1, 1'b0));
    tx.push_back(mk_tok(17'd0, 9'd0, 8'h41, 1'b0, 1'b1));
    run_frame(0);

    fill_tx(40);
    run_frame(1);

    for (int f = 0; f < 3; f++) begin
      fill_tx($urandom_range(1, 30));
      run_frame(2);
    end

    // Backpressure: nothing read, stall must cap the stored count one below depth.
    out_ready = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      if (!enc_stall) begin
        in_tok = rand_tok(1'b0);
        enc_valid_symbol = 1'b1;
        exp_q.push_back(in_tok);
        acc++;
      end else begin
        enc_valid_symbol = 1'b0;
      end
      step();
    end
    check("stall_accept_count", acc, DEPTH - 1);
    check("stall_high", enc_stall, 1);
    check("overflow_clear", overflow_err, 0);
    held = {out_position, out_length, out_next_symbol, out_is_match, out_last};
    check("held_head", held, exp_q[0]);
    repeat (5) step();
    check("held_valid", out_valid, 1);
    check("held_fields", {out_position, out_length, out_next_symbol, out_is_match, out_last}, held);

    in_tok = rand_tok(1'b0);
    enc_valid_symbol = 1'b1;
    step();
    enc_valid_symbol = 1'b0;
    check("protocol_set", protocol_err, 1);
    repeat (5) step();
    check("protocol_sticky", protocol_err, 1);
    check("overflow_untracked", overflow_err, 0);
    tx.delete();
    tx.push_back(rand_tok(1'b1));
    pump(0);

    // Reset in the middle of a frame with five tokens queued.
    out_ready = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_tok = rand_tok(1'b0);
      enc_valid_symbol = 1'b1;
      step();
    end
    enc_valid_symbol = 1'b0;
    repeat (PL + 2) step();
    check("pre_reset_valid", out_valid, 1);
    check("pre_reset_busy", busy, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_stall", enc_stall, 1);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_protocol", protocol_err, 0);
    check("no_done_on_reset", done_cnt - d0, 0);
    fill_tx(6);
    run_frame(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
